// File: rtl/ahb_ram_slave.sv
// AHB-Lite single-port RAM slave, 32-bit data, byte/halfword/word access.
// Latency: WAIT_STATES low cycles then an OKAY data phase; illegal size/alignment gives a two-cycle ERROR.
// Backpressure: hreadyout low during WAIT and ERR1; no transfer is accepted while this slave stalls.
module ahb_ram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              wcnt, wcnt_nxt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_write;
    logic [2:0]              lat_size;
    logic [31:0]             mem [WORDS];
    logic                    accept;
    logic                    illegal;
    logic [3:0]              be;
    logic                    unused_bits;

    // hreadyout gating keeps a stalled slave from taking a second transfer even if hready misbehaves
    assign accept  = hsel & hready & hreadyout & htrans[1];
    assign illegal = (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
    assign hresp     = (state == S_ERR1) || (state == S_ERR2);

    assign unused_bits = ^{hburst, haddr[31:ADDR_WIDTH], htrans[0]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            wcnt      <= 3'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= 3'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                lat_addr  <= haddr[ADDR_WIDTH-1:0];
                lat_write <= hwrite;
                lat_size  <= hsize;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_WAIT: begin
                if (wcnt == 3'd0) begin
                    state_nxt = S_DONE;
                end else begin
                    wcnt_nxt = wcnt - 3'd1;
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
            end
            default: begin
                // IDLE, DONE and ERR2 all end with hreadyout high, so a new transfer follows with no bubble
                if (accept) begin
                    if (illegal) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        wcnt_nxt  = WS_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        be = 4'b0000;
        case (lat_size)
            3'd0:    be = 4'b0001 << lat_addr[1:0];
            3'd1:    be = lat_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Storage is deliberately not reset; reset aborts a pending write by leaving DONE
    always_ff @(posedge clk) begin
        if ((state == S_DONE) && lat_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[lat_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read makes a read that directly follows a write see the updated word
    assign hrdata = ((state == S_DONE) && !lat_write) ? mem[lat_addr[ADDR_WIDTH-1:2]] : 32'h0;

endmodule
